// File: rtl/instr_ctrl_fsm.sv
// rtl/instr_ctrl_fsm.sv - 8-phase instruction sequencing controller for the 8-bit RISC core
//
// Purpose: steps a 3-bit phase counter S0..S7 once per clk1 edge while ena=1.
// S0/S1 fetch the two instruction bytes. S2 lets decode settle. S3..S7 issue
// the execute strobes for the opcode currently held in the instruction register.
// Every output is registered. The edge that leaves phase Sk loads Sk's strobe
// pattern, and that pattern is visible for the following cycle.
//
// Ports:
//   clk1        in   core clock, rising edge
//   rst         in   synchronous active-high reset (has priority over ena)
//   ena         in   machine enable; low forces S0 and clears all strobes
//   opcode[2:0] in   instruction register bits [15:13], sampled when leaving a phase
//   zero        in   accumulator-is-zero flag (used by SKZ)
//   load_ir     out  instruction register byte-load enable
//   inc_pc      out  program counter increment
//   load_pc     out  program counter load from operand address
//   load_acc    out  accumulator load from ALU
//   rd          out  memory read strobe
//   wr          out  memory write strobe
//   datactl_ena out  drive accumulator onto data bus
//   halt        out  HLT executed
//   phase[2:0]  out  phase about to be executed (debug)
//
// Build option: HALT_LATCH_EN
//   Defined: HLT at S3 enters a sticky halted state.
//   Not defined: halt is a one-cycle pulse.
module instr_ctrl_fsm (
   input  logic       clk1,
   input  logic       rst,
   input  logic       ena,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       load_ir,
   output logic       inc_pc,
   output logic       load_pc,
   output logic       load_acc,
   output logic       rd,
   output logic       wr,
   output logic       datactl_ena,
   output logic       halt,
   output logic [2:0] phase
);

   localparam logic [2:0] S0 = 3'd0;
   localparam logic [2:0] S1 = 3'd1;
   localparam logic [2:0] S2 = 3'd2;
   localparam logic [2:0] S3 = 3'd3;
   localparam logic [2:0] S4 = 3'd4;
   localparam logic [2:0] S5 = 3'd5;
   localparam logic [2:0] S6 = 3'd6;
   localparam logic [2:0] S7 = 3'd7;

   localparam logic [2:0] OP_HLT  = 3'b000;
   localparam logic [2:0] OP_SKZ  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ANDD = 3'b011;
   localparam logic [2:0] OP_XORR = 3'b100;
   localparam logic [2:0] OP_LDA  = 3'b101;
   localparam logic [2:0] OP_STO  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   // Strobe vector order: {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt}
   localparam logic [7:0] STB_NONE  = 8'b0000_0000;
   localparam logic [7:0] STB_FETCH = 8'b1100_1000;
   localparam logic [7:0] STB_HALT  = 8'b0000_0001;

   logic [7:0] strb_q;
   logic [7:0] strb_nxt;
   logic       is_alu;

`ifdef HALT_LATCH_EN
   logic halted;
`endif

   assign is_alu = (opcode == OP_ADD) || (opcode == OP_ANDD) ||
                   (opcode == OP_XORR) || (opcode == OP_LDA);

   // Strobe pattern for the phase being left. Opcode is only decoded from S3 on,
   // so changes to opcode during the fetch phases cannot reach the strobes.
   always_comb begin
      strb_nxt = STB_NONE;
      case (phase)
         S0, S1: strb_nxt = STB_FETCH;
         S3: if (opcode == OP_HLT) strb_nxt = 8'b0100_0001;
         S4: begin
            if (is_alu)                 strb_nxt = 8'b0000_1000;
            else if (opcode == OP_JMP)  strb_nxt = 8'b0010_0000;
            else if (opcode == OP_STO)  strb_nxt = 8'b0000_0010;
         end
         S5: begin
            if (is_alu)                        strb_nxt = 8'b0001_1000;
            else if (opcode == OP_SKZ && zero) strb_nxt = 8'b0100_0000;
            else if (opcode == OP_JMP)         strb_nxt = 8'b0110_0000;
            else if (opcode == OP_STO)         strb_nxt = 8'b0000_0110;
         end
         S6: begin
            if (is_alu)                 strb_nxt = 8'b0000_1000;
            else if (opcode == OP_STO)  strb_nxt = 8'b0000_0010;
         end
         S7: if (opcode == OP_SKZ && zero) strb_nxt = 8'b0100_0000;
         default: strb_nxt = STB_NONE;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (rst) begin
         phase  <= S0;
         strb_q <= STB_NONE;
`ifdef HALT_LATCH_EN
         halted <= 1'b0;
`endif
      end
`ifdef HALT_LATCH_EN
      else if (halted) begin
         // Sticky until rst; ena is deliberately ignored here.
         phase  <= S3;
         strb_q <= STB_HALT;
      end
`endif
      else if (!ena) begin
         // Abandon the instruction; the next one starts with a fresh fetch.
         phase  <= S0;
         strb_q <= STB_NONE;
      end
      else begin
`ifdef HALT_LATCH_EN
         if (phase == S3 && opcode == OP_HLT) begin
            halted <= 1'b1;
            phase  <= S3;
            strb_q <= STB_HALT;
         end
         else begin
            phase  <= phase + 3'd1;
            strb_q <= strb_nxt;
         end
`else
         phase  <= phase + 3'd1;
         strb_q <= strb_nxt;
`endif
      end
   end

   assign {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt} = strb_q;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// tb/tb_instr_ctrl_fsm.sv - self-checking bench for instr_ctrl_fsm
module tb_instr_ctrl_fsm;

   logic       clk1 = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic [2:0] opcode = 3'd0;
   logic       zero = 1'b0;
   logic       load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
   logic [2:0] phase;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state: expected phase, expected strobe vector, and the halt latch
   int         m_phase = 0;
   logic [7:0] m_strb = 8'd0;
   bit         m_halted = 0;

   instr_ctrl_fsm dut (
      .clk1(clk1), .rst(rst), .ena(ena), .opcode(opcode), .zero(zero),
      .load_ir(load_ir), .inc_pc(inc_pc), .load_pc(load_pc), .load_acc(load_acc),
      .rd(rd), .wr(wr), .datactl_ena(datactl_ena), .halt(halt), .phase(phase)
   );

   always #5 clk1 = ~clk1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Each strobe is computed directly from the instruction-cycle rules.
   // Bit order: {load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt}.
   function automatic logic [7:0] ref_strobes(input int ph, input logic [2:0] op, input logic z);
      bit fetch, alu, sto, jmp, skz_take;
      fetch    = (ph < 2);
      alu      = (op >= 3'd2 && op <= 3'd5);
      sto      = (op == 3'd6);
      jmp      = (op == 3'd7);
      skz_take = (op == 3'd1) && z;
      ref_strobes[7] = fetch;
      ref_strobes[6] = fetch || (ph == 3 && op == 3'd0) || (skz_take && (ph == 5 || ph == 7)) || (jmp && ph == 5);
      ref_strobes[5] = jmp && (ph == 4 || ph == 5);
      ref_strobes[4] = alu && ph == 5;
      ref_strobes[3] = fetch || (alu && ph >= 4 && ph <= 6);
      ref_strobes[2] = sto && ph == 5;
      ref_strobes[1] = sto && ph >= 4 && ph <= 6;
      ref_strobes[0] = (op == 3'd0) && ph == 3;
   endfunction

   task automatic tick(input logic r, input logic e, input logic [2:0] op, input logic z);
      rst = r; ena = e; opcode = op; zero = z;
      @(posedge clk1);
      if (r) begin
         m_phase = 0; m_strb = 8'd0; m_halted = 0;
      end else if (m_halted) begin
         m_strb = 8'h01;
      end else if (!e) begin
         m_phase = 0; m_strb = 8'd0;
      end else begin
         m_strb = ref_strobes(m_phase, op, z);
`ifdef HALT_LATCH_EN
         if (m_phase == 3 && op == 3'd0) begin
            m_halted = 1;
            m_strb = 8'h01;
         end else
            m_phase = (m_phase + 1) % 8;
`else
         m_phase = (m_phase + 1) % 8;
`endif
      end
      @(negedge clk1);
      check_eq("state", {21'd0, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt, phase},
               {21'd0, m_strb, m_phase[2:0]});
      check_eq("rd_wr_exclusive", {31'd0, rd & wr}, 32'd0);
      check_eq("wr_needs_datactl", {31'd0, wr & ~datactl_ena}, 32'd0);
   endtask

   // One full 8-phase instruction with ena held high; counts strobe cycles.
   task automatic run_instr(input logic [2:0] op, input logic z,
                            output int n_ir, output int n_inc, output int n_ldpc, output int n_acc,
                            output int n_rd, output int n_wr, output int n_dctl, output int n_halt);
      n_ir = 0; n_inc = 0; n_ldpc = 0; n_acc = 0; n_rd = 0; n_wr = 0; n_dctl = 0; n_halt = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1'b0, 1'b1, op, z);
         n_ir += int'(load_ir); n_inc += int'(inc_pc); n_ldpc += int'(load_pc);
         n_acc += int'(load_acc); n_rd += int'(rd); n_wr += int'(wr);
         n_dctl += int'(datactl_ena); n_halt += int'(halt);
      end
   endtask

   initial begin
      int n_ir, n_inc, n_ldpc, n_acc, n_rd, n_wr, n_dctl, n_halt;

      // Reset with ena held high
      for (int k = 0; k < 3; k++) tick(1'b1, 1'b1, 3'd6, 1'b0);
      check_eq("reset_outputs", {24'd0, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt}, 32'd0);
      check_eq("reset_phase", {29'd0, phase}, 32'd0);

      // STO, starting straight from reset release
      run_instr(3'd6, 1'b0, n_ir, n_inc, n_ldpc, n_acc, n_rd, n_wr, n_dctl, n_halt);
      check_eq("sto_load_ir_cycles", n_ir, 2);
      check_eq("sto_datactl_cycles", n_dctl, 3);
      check_eq("sto_wr_cycles", n_wr, 1);
      check_eq("sto_rd_only_fetch", n_rd, 2);
      check_eq("sto_back_to_s0", {29'd0, phase}, 32'd0);

      run_instr(3'd1, 1'b1, n_ir, n_inc, n_ldpc, n_acc, n_rd, n_wr, n_dctl, n_halt);
      check_eq("skz_taken_inc_pc", n_inc, 4);
      run_instr(3'd1, 1'b0, n_ir, n_inc, n_ldpc, n_acc, n_rd, n_wr, n_dctl, n_halt);
      check_eq("skz_not_taken_inc_pc", n_inc, 2);

      run_instr(3'd7, 1'b0, n_ir, n_inc, n_ldpc, n_acc, n_rd, n_wr, n_dctl, n_halt);
      check_eq("jmp_load_pc", n_ldpc, 2);
      check_eq("jmp_inc_pc", n_inc, 3);
      check_eq("jmp_load_acc", n_acc, 0);

      run_instr(3'd2, 1'b1, n_ir, n_inc, n_ldpc, n_acc, n_rd, n_wr, n_dctl, n_halt);
      check_eq("add_load_acc", n_acc, 1);
      check_eq("add_rd_cycles", n_rd, 5);

      // Drop ena right after S4 of an ADD, then resume
      for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 3'd2, 1'b0);
      check_eq("add_s4_rd", {31'd0, rd}, 32'd1);
      tick(1'b0, 1'b0, 3'd2, 1'b0);
      check_eq("ena_drop_strobes", {24'd0, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt}, 32'd0);
      check_eq("ena_drop_phase", {29'd0, phase}, 32'd0);
      tick(1'b0, 1'b1, 3'd2, 1'b0);
      check_eq("resume_fetch0", {31'd0, load_ir}, 32'd1);
      tick(1'b0, 1'b1, 3'd2, 1'b0);
      check_eq("resume_fetch1", {31'd0, load_ir}, 32'd1);
      tick(1'b0, 1'b1, 3'd2, 1'b0);
      check_eq("resume_fetch_done", {31'd0, load_ir}, 32'd0);
      for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 3'd2, 1'b0);
      check_eq("resume_at_s0", {29'd0, phase}, 32'd0);

`ifdef HALT_LATCH_EN
      for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 3'd0, 1'b0);
      for (int k = 0; k < 22; k++) begin
         tick(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         check_eq("halt_latched", {31'd0, halt}, 32'd1);
         check_eq("halt_phase_held", {29'd0, phase}, 32'd3);
      end
      tick(1'b1, 1'b1, 3'd0, 1'b0);
      check_eq("halt_cleared_by_rst", {28'd0, halt, phase}, 32'd0);
      tick(1'b0, 1'b1, 3'd2, 1'b0);
`else
      run_instr(3'd0, 1'b0, n_ir, n_inc, n_ldpc, n_acc, n_rd, n_wr, n_dctl, n_halt);
      check_eq("hlt_single_pulse", n_halt, 1);
      check_eq("hlt_inc_pc", n_inc, 3);
      check_eq("hlt_resume_s0", {29'd0, phase}, 32'd0);
      tick(1'b0, 1'b1, 3'd2, 1'b0);
      check_eq("hlt_refetch", {31'd0, load_ir}, 32'd1);
`endif

      // Randomized traffic checked cycle-by-cycle against the model
      for (int k = 0; k < 600; k++) begin
         tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
